// File: rtl/fifo_word_unpacker.sv
// Purpose: pop IN_WIDTH words from a registered-read FIFO and stream them as RATIO narrow slices.
// Latency: a pop at cycle t lands at t+1; its first slice is valid at t+2; then 1 slice/cycle.
// Backpressure: out_ready=0 holds out_data; pops stop once cur+nxt+in-flight holds 2 words.
// Ports: clk/reset (async, active-low), flush (sync clear of buffered words),
//        fifo_empty/fifo_pop/fifo_data (FIFO read side),
//        out_data/out_valid/out_ready/out_last (slice stream), idle (nothing held or in flight).
module fifo_word_unpacker #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 fifo_empty,
  output logic                 fifo_pop,
  input  logic [IN_WIDTH-1:0]  fifo_data,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 idle
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  logic [IN_WIDTH-1:0] cur_q, cur_d;
  logic [IN_WIDTH-1:0] nxt_q, nxt_d;
  logic                cur_v_q, cur_v_d;
  logic                nxt_v_q, nxt_v_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                inflight_q, inflight_d;

  logic [1:0]       occ;
  logic [IDX_W-1:0] sel;
  logic             fire;
  logic             at_last;
  logic             cur_free;
  logic             landing;

  // Words held or on their way: a new pop is only issued when there is a slot
  // for it to land in, so no landing can ever find both buffers full.
  assign occ = 2'(cur_v_q) + 2'(nxt_v_q) + 2'(inflight_q);

  // Gated by reset so the FIFO is not drained while this block is held in reset.
  assign fifo_pop = reset && !fifo_empty && (occ < 2'd2) && !flush;

  assign at_last  = (idx_q == IDX_LAST);
  assign fire     = cur_v_q && out_ready;
  assign cur_free = fire && at_last;
  assign landing  = inflight_q && !flush;

  assign sel       = LSB_FIRST ? idx_q : (IDX_LAST - idx_q);
  assign out_data  = cur_q[sel*OUT_WIDTH +: OUT_WIDTH];
  assign out_valid = cur_v_q;
  assign out_last  = cur_v_q && at_last;
  assign idle      = !cur_v_q && !nxt_v_q && !inflight_q;

  always_comb begin
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    cur_v_d    = cur_v_q;
    nxt_v_d    = nxt_v_q;
    idx_d      = idx_q;
    inflight_d = fifo_pop;

    if (flush) begin
      // The word landing this cycle is dropped along with everything buffered.
      cur_v_d = 1'b0;
      nxt_v_d = 1'b0;
      idx_d   = '0;
    end else begin
      if (fire) begin
        idx_d = at_last ? '0 : idx_q + IDX_W'(1);
      end

      if (cur_free) begin
        // Refill order keeps words in sequence: nxt is older than any landing word.
        if (nxt_v_q) begin
          cur_d   = nxt_q;
          nxt_v_d = 1'b0;
          if (landing) begin
            nxt_d   = fifo_data;
            nxt_v_d = 1'b1;
          end
        end else if (landing) begin
          cur_d = fifo_data;
        end else begin
          cur_v_d = 1'b0;
        end
      end else if (landing) begin
        if (!cur_v_q) begin
          cur_d   = fifo_data;
          cur_v_d = 1'b1;
        end else begin
          nxt_d   = fifo_data;
          nxt_v_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_q      <= '0;
      nxt_q      <= '0;
      cur_v_q    <= 1'b0;
      nxt_v_q    <= 1'b0;
      idx_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      cur_v_q    <= cur_v_d;
      nxt_v_q    <= nxt_v_d;
      idx_q      <= idx_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_fifo_word_unpacker.sv
// Purpose: directed and random stimulus for fifo_word_unpacker against a word/slice queue model.
// Latency: model FIFO returns data the cycle after a pop, like a registered-read FIFO.
// Backpressure: out_ready is driven directly (directed stalls and random toggling).
module tb_fifo_word_unpacker;

  localparam int IW = 64;
  localparam int OW = 8;
  localparam int R  = IW / OW;

  logic          clk = 1'b0;
  logic          reset, flush, fifo_empty, out_ready;
  logic [IW-1:0] fifo_data;
  logic          fifo_pop, out_valid, out_last, idle;
  logic [OW-1:0] out_data;
  logic          fifo_pop_m, out_valid_m, out_last_m, idle_m;
  logic [OW-1:0] out_data_m;

  always #5 clk = ~clk;

  fifo_word_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .fifo_data(fifo_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .idle(idle));

  // MS-slice-first instance sees identical inputs; its pops must match the LS-first one.
  fifo_word_unpacker #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset(reset), .flush(flush), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop_m),
    .fifo_data(fifo_data), .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
    .out_last(out_last_m), .idle(idle_m));

  typedef struct {
    logic [OW-1:0] lsb;
    logic [OW-1:0] msb;
    logic          last;
    int            idx;
  } slc_t;

  slc_t          exp_q[$];   // slices of popped words still owed downstream
  logic [IW-1:0] fifo_q[$];  // words sitting in the modelled FIFO
  int total = 0;
  int bad   = 0;
  int held  = 0;             // popped words not yet fully delivered
  int pops  = 0;
  logic s_pop, s_valid, s_last, s_idle;
  logic [OW-1:0] s_data, s_data_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: settle inputs at the falling edge, check, advance the model.
  task automatic step();
    logic [IW-1:0] pw;
    logic          popped;
    logic          exp_pop;
    slc_t          e;
    @(negedge clk);
    fifo_empty = (fifo_q.size() == 0);
    #1;
    s_pop = fifo_pop; s_valid = out_valid; s_last = out_last; s_idle = idle;
    s_data = out_data; s_data_m = out_data_m;
    exp_pop = reset && !fifo_empty && (held < 2) && !flush;
    check("pop", fifo_pop, exp_pop);
    check("pop_msb", fifo_pop_m, exp_pop);
    check("idle", idle, held == 0);
    check("idle_msb", idle_m, held == 0);
    if (out_valid) begin
      if (exp_q.size() == 0) check("spurious_valid", out_valid, 1'b0);
      else begin
        check("data", out_data, exp_q[0].lsb);
        check("last", out_last, exp_q[0].last);
      end
    end else begin
      check("last_invalid", out_last, 1'b0);
    end
    if (out_valid_m && exp_q.size() != 0) check("data_msb", out_data_m, exp_q[0].msb);
    popped = 1'b0;
    pw = '0;
    if (fifo_pop && fifo_q.size() != 0) begin
      pw = fifo_q.pop_front();
      popped = 1'b1;
      pops++;
      held++;
      for (int k = 0; k < R; k++) begin
        e.lsb  = pw[k*OW +: OW];
        e.msb  = pw[(R-1-k)*OW +: OW];
        e.last = (k == R - 1);
        e.idx  = k;
        exp_q.push_back(e);
      end
    end
    if (out_valid && out_ready && exp_q.size() != 0) begin
      if (exp_q[0].last) held--;
      void'(exp_q.pop_front());
    end
    if (flush) begin
      exp_q.delete();
      held = 0;
    end
    @(posedge clk);
    #1;
    if (popped) fifo_data = pw;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    flush = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 300) begin
      step();
      n++;
    end
    check("drain_done", 64'(exp_q.size() + fifo_q.size()), 0);
    step();
    step();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [IW-1:0] wa, wb, w1, w2;
    int fv, lv, nv, nl, p0;
    bit found;

    reset = 1'b0; flush = 1'b0; out_ready = 1'b0; fifo_empty = 1'b1; fifo_data = '0;
    #3;
    check("rst_pop", fifo_pop, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_data", out_data, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    // 1: one known word, slices 01..08 back to back, one pop.
    fifo_q.push_back(64'h0807060504030201);
    out_ready = 1'b1;
    p0 = pops; fv = -1; lv = -1; nv = 0; nl = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (s_valid) begin
        if (fv < 0) fv = i;
        nv++;
        if (fv == i) check("t1_first", s_data, 8'h01);
      end
      if (s_last) begin nl++; lv = i; end
    end
    check("t1_latency", fv, 2);
    check("t1_nvalid", nv, 8);
    check("t1_lastpos", lv - fv, 7);
    check("t1_nlast", nl, 1);
    check("t1_pops", pops - p0, 1);

    // 2: three preloaded words stream as 24 slices with no bubble.
    for (int i = 0; i < 3; i++) fifo_q.push_back({$urandom, $urandom});
    fv = -1; lv = -1; nv = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      if (s_valid) begin
        if (fv < 0) fv = i;
        lv = i;
        nv++;
      end
    end
    check("t2_nvalid", nv, 24);
    check("t2_span", lv - fv, 23);

    // 3: stall 10 cycles on slice 3; data held, at most 2 pops.
    wa = {$urandom, $urandom};
    fifo_q.push_back(wa);
    fifo_q.push_back({$urandom, $urandom});
    fifo_q.push_back({$urandom, $urandom});
    p0 = pops;
    found = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && !found; i++) begin
      if (exp_q.size() != 0 && exp_q[0].idx == 3) found = 1'b1;
      else step();
    end
    check("t3_reach", found, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t3_hold_valid", s_valid, 1'b1);
      check("t3_hold_data", s_data, wa[3*OW +: OW]);
    end
    check("t3_pops", pops - p0, 2);
    out_ready = 1'b1;
    step();
    check("t3_resume", s_data, wa[3*OW +: OW]);
    drain();

    // 4: FIFO runs dry on the last slice; refill latency is 2 cycles.
    wa = {$urandom, $urandom};
    wb = {$urandom, $urandom};
    fifo_q.push_back(wa);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (s_last) found = 1'b1;
    end
    check("t4_seen_last", found, 1'b1);
    step();
    check("t4_drop", s_valid, 1'b0);
    step();
    step();
    fifo_q.push_back(wb);
    step();
    check("t4_pop", s_pop, 1'b1);
    check("t4_v0", s_valid, 1'b0);
    step();
    check("t4_v1", s_valid, 1'b0);
    step();
    check("t4_v2", s_valid, 1'b1);
    check("t4_data", s_data, wb[OW-1:0]);
    drain();

    // 5: flush while a word lands; it is discarded, the next word is intact.
    w1 = {$urandom, $urandom};
    w2 = {$urandom, $urandom};
    fifo_q.push_back(w1);
    fifo_q.push_back(w2);
    out_ready = 1'b0;
    step();
    flush = 1'b1;
    step();
    check("t5_flush_pop", s_pop, 1'b0);
    flush = 1'b0;
    step();
    check("t5_valid", s_valid, 1'b0);
    check("t5_idle", s_idle, 1'b1);
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (s_valid) begin
        found = 1'b1;
        check("t5_next", s_data, w2[OW-1:0]);
      end
    end
    check("t5_seen", found, 1'b1);
    drain();

    // 6: reset at slice 5; outputs clear at once, next word starts at slice 0.
    fifo_q.push_back({$urandom, $urandom});
    fifo_q.push_back({$urandom, $urandom});
    out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (exp_q.size() != 0 && exp_q[0].idx == 5) found = 1'b1;
      else step();
    end
    check("t6_reach", found, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check("t6_pop", fifo_pop, 1'b0);
    check("t6_valid", out_valid, 1'b0);
    check("t6_last", out_last, 1'b0);
    check("t6_data", out_data, 8'h00);
    check("t6_data_msb", out_data_m, 8'h00);
    check("t6_idle", idle, 1'b1);
    exp_q.delete();
    held = 0;
    wa = {$urandom, $urandom};
    fifo_q.delete();
    fifo_q.push_back(wa);
    reset = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (s_valid) begin
        found = 1'b1;
        check("t6_first", s_data, wa[OW-1:0]);
        check("t6_first_msb", s_data_m, wa[IW-1 -: OW]);
      end
    end
    check("t6_seen", found, 1'b1);
    drain();

    // Random traffic: sporadic pushes, ready toggling, rare flushes.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 4) fifo_q.push_back({$urandom, $urandom});
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
